// File: rtl/demux12_3_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : demux12_3_reg_if
// Description : Producer/consumer bundle for the registered 1-to-4 demux.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux12_3_reg_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] in;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] outA, outB, outC, outD;
  logic             validA, validB, validC, validD;
  logic             readyA, readyB, readyC, readyD;

  logic             busy;
  logic [7:0]       xfer_cnt;

  // Environment side: one producer plus the four lane consumers.
  modport master (
    output in, sel, in_valid,
    output readyA, readyB, readyC, readyD,
    input  in_ready,
    input  outA, outB, outC, outD,
    input  validA, validB, validC, validD,
    input  busy, xfer_cnt
  );

  modport slave (
    input  in, sel, in_valid,
    input  readyA, readyB, readyC, readyD,
    output in_ready,
    output outA, outB, outC, outD,
    output validA, validB, validC, validD,
    output busy, xfer_cnt
  );
endinterface
`default_nettype wire

// File: rtl/demux12_3_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux12_3_reg
// Description : Steers one input word into one of four one-entry lane
//               holding registers, each drained by its own valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module demux12_3_reg #(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  demux12_3_reg_if.slave        bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  logic [3:0]       lane_ready;
  logic [3:0]       lane_valid;
  logic [WIDTH-1:0] lane_data [4];
  logic             in_ready;
  logic             accept;
  logic [7:0]       xfer_cnt_q, xfer_cnt_d;

  assign lane_ready = {bus.readyD, bus.readyC, bus.readyB, bus.readyA};

  // A full lane still accepts when it drains on the same edge, so no bubble.
  assign in_ready = ~lane_valid[bus.sel] | lane_ready[bus.sel];
  assign accept   = bus.in_valid & in_ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    lane_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;
    logic             drain;

    assign load  = accept & (bus.sel == 2'(gi));
    assign drain = (state_q == FULL) & lane_ready[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
      end
    end

    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
        EMPTY: begin
          if (load) begin
            state_d = FULL;
            data_d  = bus.in;
          end
        end
        FULL: begin
          if (load) begin
            data_d = bus.in;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    assign lane_valid[gi] = (state_q == FULL);
    assign lane_data[gi]  = data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= 8'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (accept) begin
      xfer_cnt_d = xfer_cnt_q + 8'd1;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.outA     = lane_data[0];
  assign bus.outB     = lane_data[1];
  assign bus.outC     = lane_data[2];
  assign bus.outD     = lane_data[3];
  assign bus.validA   = lane_valid[0];
  assign bus.validB   = lane_valid[1];
  assign bus.validC   = lane_valid[2];
  assign bus.validD   = lane_valid[3];
  assign bus.busy     = |lane_valid;
  assign bus.xfer_cnt = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux12_3_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux12_3_reg
// Description : Scoreboard bench; each lane is modelled as a FIFO of depth one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux12_3_reg;
  localparam int WIDTH = 3;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_chk;
  int   n_fail;
  bit   mon_en;
  bit   exp_rdy;
  int   exp_cnt;

  logic [WIDTH-1:0] lane_q [4][$];

  demux12_3_reg_if #(.WIDTH(WIDTH)) bus ();

  demux12_3_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] lane_out(input int i);
    case (i)
      0:       return bus.outA;
      1:       return bus.outB;
      2:       return bus.outC;
      default: return bus.outD;
    endcase
  endfunction

  function automatic logic lane_valid(input int i);
    case (i)
      0:       return bus.validA;
      1:       return bus.validB;
      2:       return bus.validC;
      default: return bus.validD;
    endcase
  endfunction

  function automatic logic lane_ready(input int i);
    case (i)
      0:       return bus.readyA;
      1:       return bus.readyB;
      2:       return bus.readyC;
      default: return bus.readyD;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the lane queues, pops on each drain.
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      int s;
      bit any;
      s       = int'(bus.sel);
      exp_rdy = (lane_q[s].size() == 0) || lane_ready(s);
      chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
      chk("xfer_cnt", int'(bus.xfer_cnt), exp_cnt);
      any = 1'b0;
      for (int i = 0; i < 4; i++) begin
        any = any || (lane_q[i].size() != 0);
        chk($sformatf("valid%0d", i), int'(lane_valid(i)), int'(lane_q[i].size() != 0));
        if (lane_q[i].size() != 0) begin
          chk($sformatf("out%0d", i), int'(lane_out(i)), int'(lane_q[i][0]));
          if (lane_ready(i)) void'(lane_q[i].pop_front());
        end
      end
      chk("busy", int'(bus.busy), int'(any));
    end
  end

  // One clock of stimulus; the expected response is queued after the monitor.
  task automatic cyc(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                     input logic [3:0] r);
    @(negedge clk);
    bus.in_valid = v;
    bus.sel      = s;
    bus.in       = d;
    {bus.readyD, bus.readyC, bus.readyB, bus.readyA} = r;
    #2;
    if (v) n_vec++;
    if (v && exp_rdy && mon_en) begin
      lane_q[s].push_back(d);
      exp_cnt = (exp_cnt + 1) % 256;
    end
  endtask

  task automatic random_run(input int n, input int ready_pct, input int valid_pct);
    bit               held;
    logic [1:0]       s;
    logic [WIDTH-1:0] d;
    held = 1'b0;
    s    = 2'd0;
    d    = '0;
    for (int k = 0; k < n; k++) begin
      logic [3:0] r;
      bit         v;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(99) < ready_pct);
      if (held) begin
        v = 1'b1;
      end else begin
        v = ($urandom_range(99) < valid_pct);
        s = 2'($urandom_range(3));
        d = WIDTH'($urandom);
      end
      cyc(v, s, d, r);
      held = v && !exp_rdy;
    end
  endtask

  initial begin
    n_vec   = 0;
    n_chk   = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    exp_rdy = 1'b1;
    exp_cnt = 0;
    rst_n   = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel      = 2'd0;
    bus.in       = '0;
    {bus.readyD, bus.readyC, bus.readyB, bus.readyA} = 4'h0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    repeat (3) cyc(1'b0, 2'd0, '0, 4'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_out%0d", i), int'(lane_out(i)), 0);

    // Lane C load, refusal while full, then simultaneous drain + load.
    cyc(1'b1, 2'd2, 3'b101, 4'h0);
    cyc(1'b1, 2'd2, 3'b011, 4'h0);
    cyc(1'b1, 2'd2, 3'b011, 4'h0);
    cyc(1'b1, 2'd2, 3'b011, 4'b0100);
    cyc(1'b0, 2'd0, '0, 4'b0100);
    cyc(1'b0, 2'd0, '0, 4'h0);

    // Full lane A does not block a load into lane B; both drain together.
    cyc(1'b1, 2'd0, 3'b010, 4'h0);
    cyc(1'b1, 2'd1, 3'b110, 4'h0);
    cyc(1'b0, 2'd0, '0, 4'b0011);
    cyc(1'b0, 2'd0, '0, 4'h0);

    // Back-to-back accepts across the counter wrap.
    for (int k = 0; k < 256; k++) cyc(1'b1, 2'(k % 4), WIDTH'($urandom), 4'hF);
    cyc(1'b0, 2'd0, '0, 4'hF);

    random_run(1500, 60, 70);
    random_run(800, 20, 90);
    random_run(800, 95, 50);

    // Asynchronous reset between edges while lanes A and D hold data.
    cyc(1'b0, 2'd0, '0, 4'hF);
    cyc(1'b1, 2'd0, 3'b111, 4'h0);
    cyc(1'b1, 2'd3, 3'b101, 4'h0);
    cyc(1'b0, 2'd0, '0, 4'h0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("arst_validA", int'(bus.validA), 0);
    chk("arst_validD", int'(bus.validD), 0);
    chk("arst_outA", int'(bus.outA), 0);
    chk("arst_outD", int'(bus.outD), 0);
    chk("arst_xfer_cnt", int'(bus.xfer_cnt), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) lane_q[i].delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc(1'b1, 2'd1, 3'b100, 4'h0);
    cyc(1'b0, 2'd0, '0, 4'h0);
    chk("post_rst_outB", int'(bus.outB), 4);

    random_run(400, 50, 60);
    cyc(1'b0, 2'd0, '0, 4'hF);
    cyc(1'b0, 2'd0, '0, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
